// File: rtl/hilo_pkg.sv
// Shared types and constants for the Hi/Lo sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

    // Operation encoding as presented on the Op input.
    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        WAIT   = 2'b10,
        COMMIT = 2'b11
    } state_t;

    // Latency counter width; holds LAT-2 for any latency up to 257 cycles.
    localparam int CNT_W = 8;

    // Counter preload for a unit of latency lat. WAIT lasts lat-1 cycles and
    // the counter leaves WAIT when it reads zero, so it starts at lat-2.
    function automatic logic [CNT_W-1:0] lat_preload(input int lat);
        return CNT_W'(lat - 2);
    endfunction

endpackage

// File: rtl/hilo_sequencer_lat_counter.sv
// Down-counter that times a multicycle unit: load / decrement / zero flag.
// Latency: load or decrement visible one cycle after the request.
// Backpressure: none; decrement saturates at zero.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         load load_val_i (has priority over dec_i)
//   load_val_i     preload value
//   dec_i          decrement by one when non-zero
//   zero_o         counter currently reads zero
module lat_counter
    import hilo_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hilo_sequencer.sv
// Owns architectural Hi/Lo; issues mult/div start pulses, times each unit, commits results.
// Latency: MTHI/MTLO/div-by-zero Done next cycle; MULT/DIV Done LAT+2 cycles after accept.
// Backpressure: Ready low outside IDLE (Start ignored, requester holds); Stall holds mfhi/mflo readers.
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   Start, Op, SrcA, SrcB      operation request, accepted only while Ready
//   Ready                      sequencer idle
//   ReadReq, Stall             mfhi/mflo read request and its hold
//   MultControl, MultA, MultB  start pulse and operands to the multiplier
//   MultHi, MultLo             multiplier result
//   DivControl, DivA, DivB     start pulse and operands to the divider
//   DivHi, DivLo               divider result (Hi remainder, Lo quotient)
//   Hi, Lo                     architectural Hi/Lo
//   Done                       one-cycle pulse after Hi/Lo update
//   DivZero                    sticky divide-by-zero flag
//
// Build option HILO_FWD_EN: forward the unit result onto Hi/Lo during COMMIT
// and release Stall one cycle earlier.
module hilo_sequencer
    import hilo_pkg::*;
#(
    parameter int MULT_LAT = 2,
    parameter int DIV_LAT  = 34
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Ready,
    input  logic        ReadReq,
    output logic        Stall,
    output logic        MultControl,
    output logic [31:0] MultA,
    output logic [31:0] MultB,
    input  logic [31:0] MultHi,
    input  logic [31:0] MultLo,
    output logic        DivControl,
    output logic [31:0] DivA,
    output logic [31:0] DivB,
    input  logic [31:0] DivHi,
    input  logic [31:0] DivLo,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Done,
    output logic        DivZero
);

    if (MULT_LAT < 2 || DIV_LAT < 2 ||
        MULT_LAT - 2 >= (1 << CNT_W) || DIV_LAT - 2 >= (1 << CNT_W)) begin : g_bad_lat
        $error("hilo_sequencer: latencies must be >= 2 and fit the counter");
    end

    state_t      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        sel_div_q;
    logic        mult_ctl_q;
    logic        div_ctl_q;
    logic        done_q;
    logic        divzero_q;

    op_t         op;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic [CNT_W-1:0] cnt_preload;

    assign op = op_t'(Op);

    // Result of whichever unit the in-flight operation was issued to.
    assign res_hi = sel_div_q ? DivHi : MultHi;
    assign res_lo = sel_div_q ? DivLo : MultLo;

    assign cnt_load    = (state_q == ISSUE);
    assign cnt_dec     = (state_q == WAIT);
    assign cnt_preload = sel_div_q ? lat_preload(DIV_LAT) : lat_preload(MULT_LAT);

    lat_counter u_lat_counter (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_preload),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Control pulses and Done are registered: they default low every cycle
    // and are set only on the edge that enters the state they belong to.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            sel_div_q  <= 1'b0;
            mult_ctl_q <= 1'b0;
            div_ctl_q  <= 1'b0;
            done_q     <= 1'b0;
            divzero_q  <= 1'b0;
        end else begin
            mult_ctl_q <= 1'b0;
            div_ctl_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        case (op)
                            OP_MULT: begin
                                opa_q      <= SrcA;
                                opb_q      <= SrcB;
                                sel_div_q  <= 1'b0;
                                mult_ctl_q <= 1'b1;
                                state_q    <= ISSUE;
                            end
                            OP_DIV: begin
                                if (SrcB == '0) begin
                                    // Never bother the divider; flag and complete at once.
                                    divzero_q <= 1'b1;
                                    done_q    <= 1'b1;
                                end else begin
                                    opa_q     <= SrcA;
                                    opb_q     <= SrcB;
                                    sel_div_q <= 1'b1;
                                    div_ctl_q <= 1'b1;
                                    state_q   <= ISSUE;
                                end
                            end
                            OP_MTHI: begin
                                hi_q   <= SrcA;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= SrcA;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ready       = (state_q == IDLE);
    assign MultControl = mult_ctl_q;
    assign DivControl  = div_ctl_q;
    assign MultA       = opa_q;
    assign MultB       = opb_q;
    assign DivA        = opa_q;
    assign DivB        = opb_q;
    assign Done        = done_q;
    assign DivZero     = divzero_q;

`ifdef HILO_FWD_EN
    // In COMMIT the unit result is already valid, so readers may take it directly.
    assign Hi    = (state_q == COMMIT) ? res_hi : hi_q;
    assign Lo    = (state_q == COMMIT) ? res_lo : lo_q;
    assign Stall = ReadReq & (state_q != IDLE) & (state_q != COMMIT);
`else
    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign Stall = ReadReq & (state_q != IDLE);
`endif

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed self-checking bench for hilo_sequencer with behavioural mult/div units.
module tb_hilo_sequencer;

`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Ready;
    logic        ReadReq;
    logic        Stall;
    logic        MultControl;
    logic [31:0] MultA;
    logic [31:0] MultB;
    logic [31:0] MultHi;
    logic [31:0] MultLo;
    logic        DivControl;
    logic [31:0] DivA;
    logic [31:0] DivB;
    logic [31:0] DivHi;
    logic [31:0] DivLo;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Done;
    logic        DivZero;

    int n_chk  = 0;
    int n_fail = 0;

    hilo_sequencer #(.MULT_LAT(2), .DIV_LAT(34)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .Ready(Ready), .ReadReq(ReadReq), .Stall(Stall),
        .MultControl(MultControl), .MultA(MultA), .MultB(MultB),
        .MultHi(MultHi), .MultLo(MultLo),
        .DivControl(DivControl), .DivA(DivA), .DivB(DivB),
        .DivHi(DivHi), .DivLo(DivLo),
        .Hi(Hi), .Lo(Lo), .Done(Done), .DivZero(DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural signed multiplier and divider working off the held operands.
    logic signed [63:0] prod;
    always_comb begin
        prod   = $signed({{32{MultA[31]}}, MultA}) * $signed({{32{MultB[31]}}, MultB});
        MultHi = prod[63:32];
        MultLo = prod[31:0];
        DivHi  = 32'd0;
        DivLo  = 32'd0;
        if (DivB != 32'd0) begin
            DivHi = $signed(DivA) % $signed(DivB);
            DivLo = $signed(DivA) / $signed(DivB);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        Op      = 2'b00;
        SrcA    = '0;
        SrcB    = '0;
        ReadReq = 1'b1;
        tick();
        tick();
        chk("rst_ready",   32'(Ready),       32'd1);
        chk("rst_hi",      Hi,               32'd0);
        chk("rst_lo",      Lo,               32'd0);
        chk("rst_done",    32'(Done),        32'd0);
        chk("rst_divzero", 32'(DivZero),     32'd0);
        chk("rst_mctl",    32'(MultControl), 32'd0);
        chk("rst_dctl",    32'(DivControl),  32'd0);
        chk("rst_stall",   32'(Stall),       32'd0);
        Reset   = 1'b0;
        ReadReq = 1'b0;
        tick();

        // MULT 7 x -3, reader in the same IDLE cycle sees old Hi without stall.
        req(2'b00, 32'd7, 32'hFFFF_FFFD);
        ReadReq = 1'b1;
        chk("m1_c0_stall", 32'(Stall), 32'd0);
        chk("m1_c0_hi",    Hi,         32'd0);
        tick();
        Start = 1'b0;
        ReadReq = 1'b0;
        chk("m1_c1_mctl",  32'(MultControl), 32'd1);
        chk("m1_c1_dctl",  32'(DivControl),  32'd0);
        chk("m1_c1_ready", 32'(Ready),       32'd0);
        chk("m1_c1_a",     MultA,            32'd7);
        chk("m1_c1_b",     MultB,            32'hFFFF_FFFD);
        tick();
        chk("m1_c2_mctl",  32'(MultControl), 32'd0);
        tick();
        chk("m1_c3_done",  32'(Done),        32'd0);
        chk("m1_c3_mctl",  32'(MultControl), 32'd0);
        tick();
        chk("m1_c4_hi",    Hi,               32'hFFFF_FFFF);
        chk("m1_c4_lo",    Lo,               32'hFFFF_FFEB);
        chk("m1_c4_done",  32'(Done),        32'd1);
        chk("m1_c4_ready", 32'(Ready),       32'd1);
        tick();
        chk("m1_c5_done",  32'(Done),        32'd0);

        // MULT 3 x 5 with the reader held: release point depends on forwarding.
        req(2'b00, 32'd3, 32'd5);
        ReadReq = 1'b1;
        tick();
        Start = 1'b0;
        chk("m2_c1_stall", 32'(Stall), 32'd1);
        tick();
        chk("m2_c2_stall", 32'(Stall), 32'd1);
        tick();
        chk("m2_c3_stall", 32'(Stall), FWD ? 32'd0 : 32'd1);
        chk("m2_c3_lo",    Lo,         FWD ? 32'd15 : 32'hFFFF_FFEB);
        tick();
        chk("m2_c4_stall", 32'(Stall), 32'd0);
        chk("m2_c4_lo",    Lo,         32'd15);
        chk("m2_c4_hi",    Hi,         32'd0);
        chk("m2_c4_done",  32'(Done),  32'd1);
        ReadReq = 1'b0;
        tick();

        // DIV 100 / 7 with the reader held for the whole operation.
        req(2'b01, 32'd100, 32'd7);
        ReadReq = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            tick();
            Start = 1'b0;
            chk($sformatf("d1_c%0d_stall", c), 32'(Stall),
                (FWD && c == 35) ? 32'd0 : 32'd1);
            chk($sformatf("d1_c%0d_done", c), 32'(Done), 32'd0);
            chk($sformatf("d1_c%0d_dctl", c), 32'(DivControl), (c == 1) ? 32'd1 : 32'd0);
            chk($sformatf("d1_c%0d_mctl", c), 32'(MultControl), 32'd0);
            if (c == 1) begin
                chk("d1_c1_a", DivA, 32'd100);
                chk("d1_c1_b", DivB, 32'd7);
            end
        end
        tick();
        chk("d1_c36_hi",    Hi,         32'd2);
        chk("d1_c36_lo",    Lo,         32'd14);
        chk("d1_c36_done",  32'(Done),  32'd1);
        chk("d1_c36_stall", 32'(Stall), 32'd0);
        ReadReq = 1'b0;
        tick();

        // DIV by zero: no issue, Hi/Lo untouched, sticky flag, immediate Done.
        req(2'b01, 32'd5, 32'd0);
        chk("dz_c0_divzero", 32'(DivZero), 32'd0);
        tick();
        Start = 1'b0;
        chk("dz_c1_done",    32'(Done),       32'd1);
        chk("dz_c1_divzero", 32'(DivZero),    32'd1);
        chk("dz_c1_dctl",    32'(DivControl), 32'd0);
        chk("dz_c1_ready",   32'(Ready),      32'd1);
        chk("dz_c1_hi",      Hi,              32'd2);
        chk("dz_c1_lo",      Lo,              32'd14);
        tick();
        chk("dz_c2_done",    32'(Done),       32'd0);
        chk("dz_c2_divzero", 32'(DivZero),    32'd1);
        chk("dz_c2_dctl",    32'(DivControl), 32'd0);

        // MTHI, then MULT 6 x 4, then an MTLO held while busy.
        req(2'b10, 32'h0000_1234, 32'd0);
        tick();
        chk("mv_c1_hi",    Hi,         32'h0000_1234);
        chk("mv_c1_done",  32'(Done),  32'd1);
        chk("mv_c1_ready", 32'(Ready), 32'd1);
        req(2'b00, 32'd6, 32'd4);
        tick();
        chk("mv_c2_mctl",  32'(MultControl), 32'd1);
        chk("mv_c2_ready", 32'(Ready),       32'd0);
        req(2'b11, 32'h0000_AAAA, 32'h0000_5555);
        tick();
        chk("mv_c3_a",     MultA,      32'd6);
        chk("mv_c3_b",     MultB,      32'd4);
        chk("mv_c3_hi",    Hi,         32'h0000_1234);
        tick();
        chk("mv_c4_a",     MultA,      32'd6);
        chk("mv_c4_ready", 32'(Ready), 32'd0);
        chk("mv_c4_lo",    Lo,         FWD ? 32'd24 : 32'd14);
        tick();
        chk("mv_c5_hi",    Hi,         32'd0);
        chk("mv_c5_lo",    Lo,         32'd24);
        chk("mv_c5_done",  32'(Done),  32'd1);
        chk("mv_c5_ready", 32'(Ready), 32'd1);
        tick();
        Start = 1'b0;
        chk("mv_c6_lo",    Lo,         32'h0000_AAAA);
        chk("mv_c6_hi",    Hi,         32'd0);
        chk("mv_c6_done",  32'(Done),  32'd1);
        tick();

        // Reset in the middle of a DIV wait abandons it.
        req(2'b00, 32'd9, 32'd9);
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("rw_pre_hi", Hi, 32'd0);
        chk("rw_pre_lo", Lo, 32'd81);
        req(2'b01, 32'd50, 32'd3);
        tick();
        Start = 1'b0;
        repeat (9) tick();
        chk("rw_c10_ready", 32'(Ready),      32'd0);
        chk("rw_c10_dctl",  32'(DivControl), 32'd0);
        Reset = 1'b1;
        #1;
        chk("rw_async_ready",   32'(Ready),       32'd1);
        chk("rw_async_hi",      Hi,               32'd0);
        chk("rw_async_lo",      Lo,               32'd0);
        chk("rw_async_divzero", 32'(DivZero),     32'd0);
        tick();
        Reset = 1'b0;
        chk("rw_c11_ready", 32'(Ready),       32'd1);
        chk("rw_c11_mctl",  32'(MultControl), 32'd0);
        chk("rw_c11_done",  32'(Done),        32'd0);
        begin
            int late_done;
            late_done = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (Done) late_done++;
            end
            chk("rw_no_done", 32'(late_done), 32'd0);
        end
        chk("rw_end_hi", Hi, 32'd0);
        chk("rw_end_lo", Lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
